// File: rtl/r2sdf_fxp_stage_pkg.sv
// Shared definitions for the fixed-point R2SDF FFT stages.
//   acc_t / cplx_t : wide signed container for full-precision intermediate products
//   rnd_sat        : round half-up at a bit position, then saturate to a signed width
//   twiddle_rom    : quantised twiddle value, evaluated at elaboration time
package r2sdf_fxp_stage_pkg;

    localparam int MAX_LOG2N = 12;
    localparam int ACC_W     = 64;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        acc_t re;
        acc_t im;
    } cplx_t;

    // Arithmetic shift right by 'shift' with half-LSB added first (half toward +inf),
    // then clamp into the range of an 'ow'-bit two's complement value.
    function automatic acc_t rnd_sat(input acc_t val, input int shift, input int ow);
        acc_t r;
        acc_t hi;
        acc_t lo;
        r = val;
        if (shift > 0)
            r = (val + (acc_t'(1) <<< (shift - 1))) >>> shift;
        hi = (acc_t'(1) <<< (ow - 1)) - acc_t'(1);
        lo = -hi - acc_t'(1);
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

    // W^k = exp(-j*2*pi*k/2^log2n) in Q1.(tw-1); +1.0 maps to 2^(tw-1)-1 so the
    // table never needs the unrepresentable +2^(tw-1). im=1 selects the imaginary part.
    function automatic int twiddle_rom(input int log2n, input int tw, input int k, input bit im);
        real ang;
        real amp;
        real v;
        if (log2n > MAX_LOG2N)
            return 0;
        ang = 6.283185307179586 * real'(k) / real'(1 << log2n);
        amp = real'((1 << (tw - 1)) - 1);
        v   = im ? -$sin(ang) * amp : $cos(ang) * amp;
        return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    endfunction

endpackage

// File: rtl/r2sdf_fxp_stage_delay.sv
// Feedback delay line of an R2SDF stage (read-before-write, advances on en).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : advance the line by one entry
//   d          : value written this cycle
//   q          : value written DEPTH enabled cycles earlier
module r2sdf_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 1) begin : g_reg
        logic [W-1:0] r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r <= '0;
            else if (clr)
                r <= '0;
            else if (en)
                r <= d;
        end
        assign q = r;
    end else if (DEPTH < 32) begin : g_sr
        logic [W-1:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++)
                    sr[i] <= '0;
            end else if (clr) begin
                for (int i = 0; i < DEPTH; i++)
                    sr[i] <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++)
                    sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end else begin : g_ram
        // Deep lines use a circular buffer so they can map onto RAM. Only the pointer
        // is cleared: every entry is rewritten before its read can be flagged valid.
        localparam int PW = $clog2(DEPTH);
        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] ptr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ptr <= '0;
            else if (clr)
                ptr <= '0;
            else if (en)
                ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
        always_ff @(posedge clk) begin
            if (en && !clr)
                mem[ptr] <= d;
        end
        assign q = mem[ptr];
    end

endmodule

// File: rtl/r2sdf_fxp_stage.sv
// One fixed-point radix-2 DIF single-path-delay-feedback FFT stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of counter, delay line, primed flag and outputs
//   inv               : 1 = inverse (conjugated twiddles), sampled at each frame start
//   in_valid/re/im    : input sample stream
//   out_valid/re/im   : output stream, two cycles after the accepting cycle
module r2sdf_fxp_stage
    import r2sdf_fxp_stage_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int S     = 1,
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int SCALE = 1,
    localparam int OW   = (SCALE != 0) ? DW : DW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 inv,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im
);

    localparam int D    = 1 << (LOG2N - S);
    localparam int CNTW = LOG2N - S + 1;
    localparam int BW   = DW + 1;

    logic [CNTW-1:0]      cnt;
    logic                 primed;
    logic                 inv_q;
    logic                 ph;
    logic                 inv_eff;
    logic                 dl_en;

    logic signed [BW-1:0] x_re, x_im;
    logic signed [BW-1:0] dl_re, dl_im;
    logic signed [BW-1:0] sum_re, sum_im;
    logic signed [BW-1:0] dif_re, dif_im;
    logic signed [BW-1:0] dl_d_re, dl_d_im;

    logic signed [TW-1:0] rom_re [D];
    logic signed [TW-1:0] rom_im [D];
    logic signed [TW-1:0] w_re, w_im;

    logic                 s1_v, s1_a;
    logic signed [BW-1:0] s1_re, s1_im;
    logic signed [TW-1:0] s1_wr, s1_wi;
    cplx_t                prod;

    assign ph      = cnt[CNTW-1];
    assign x_re    = BW'(in_re);
    assign x_im    = BW'(in_im);
    assign dl_en   = in_valid & ~flush;
    // The sample at cnt==0 already belongs to the new frame, so it sees inv directly.
    assign inv_eff = (cnt == '0) ? inv : inv_q;

    always_comb begin
        sum_re  = BW'(rnd_sat(acc_t'(dl_re) + acc_t'(x_re), SCALE, BW));
        sum_im  = BW'(rnd_sat(acc_t'(dl_im) + acc_t'(x_im), SCALE, BW));
        dif_re  = BW'(rnd_sat(acc_t'(dl_re) - acc_t'(x_re), SCALE, BW));
        dif_im  = BW'(rnd_sat(acc_t'(dl_im) - acc_t'(x_im), SCALE, BW));
        dl_d_re = ph ? dif_re : x_re;
        dl_d_im = ph ? dif_im : x_im;
    end

    r2sdf_delay_line #(.DEPTH(D), .W(BW)) u_dl_re (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (dl_en),
        .d     (dl_d_re),
        .q     (dl_re)
    );

    r2sdf_delay_line #(.DEPTH(D), .W(BW)) u_dl_im (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (dl_en),
        .d     (dl_d_im),
        .q     (dl_im)
    );

    for (genvar i = 0; i < D; i++) begin : g_rom
        localparam int WR = twiddle_rom(LOG2N, TW, i << (S - 1), 1'b0);
        localparam int WI = twiddle_rom(LOG2N, TW, i << (S - 1), 1'b1);
        assign rom_re[i] = TW'(WR);
        assign rom_im[i] = TW'(WI);
    end

    if (D > 1) begin : g_idx
        assign w_re = rom_re[cnt[CNTW-2:0]];
        assign w_im = rom_im[cnt[CNTW-2:0]];
    end else begin : g_one
        assign w_re = rom_re[0];
        assign w_im = rom_im[0];
    end

    always_comb begin
        prod.re = acc_t'(s1_re) * acc_t'(s1_wr) - acc_t'(s1_im) * acc_t'(s1_wi);
        prod.im = acc_t'(s1_re) * acc_t'(s1_wi) + acc_t'(s1_im) * acc_t'(s1_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            inv_q     <= 1'b0;
            s1_v      <= 1'b0;
            s1_a      <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_wr     <= '0;
            s1_wi     <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (flush) begin
            cnt       <= '0;
            primed    <= 1'b0;
            inv_q     <= 1'b0;
            s1_v      <= 1'b0;
            s1_a      <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_wr     <= '0;
            s1_wi     <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            if (in_valid) begin
                cnt <= cnt + CNTW'(1);
                if (cnt == '0)
                    inv_q <= inv;
                if (&cnt)
                    primed <= 1'b1;
            end
            // Phase-A outputs before the first full frame carry no real difference data.
            s1_v  <= in_valid & (ph | primed);
            s1_a  <= ~ph;
            s1_re <= ph ? sum_re : dl_re;
            s1_im <= ph ? sum_im : dl_im;
            s1_wr <= w_re;
            s1_wi <= inv_eff ? -w_im : w_im;

            out_valid <= s1_v;
            out_re    <= s1_a ? OW'(rnd_sat(prod.re, TW - 1, OW)) : OW'(rnd_sat(acc_t'(s1_re), 0, OW));
            out_im    <= s1_a ? OW'(rnd_sat(prod.im, TW - 1, OW)) : OW'(rnd_sat(acc_t'(s1_im), 0, OW));
        end
    end

endmodule

// File: tb/tb_r2sdf_fxp_stage.sv
module tb_r2sdf_fxp_stage;

    localparam int LOG2N = 3;
    localparam int S     = 1;
    localparam int DW    = 16;
    localparam int TW    = 16;
    localparam int SCALE = 1;
    localparam int OW    = (SCALE != 0) ? DW : DW + 1;
    localparam int NPTS  = 1 << LOG2N;
    localparam int HALF  = NPTS / 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 inv;
    logic                 in_valid;
    logic signed [DW-1:0] in_re, in_im;
    logic                 out_valid;
    logic signed [OW-1:0] out_re, out_im;

    r2sdf_fxp_stage #(.LOG2N(LOG2N), .S(S), .DW(DW), .TW(TW), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .inv       (inv),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint re;
        longint im;
        int     tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference: a frame is NPTS consecutive accepted samples. The second half of frame f
    // emits x[n-HALF]+x[n]; the first half of frame f emits (x'[n]-x'[n+HALF])*W^n of the
    // previous frame x', with W conjugated when inv was 1 at the first sample of frame f.
    longint prv_re[NPTS], prv_im[NPTS], cur_re[NPTS], cur_im[NPTS];
    int     pos;
    bit     have_prev;
    bit     frame_inv;

    function automatic longint clamp(longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint scl(longint v);
        return (SCALE != 0) ? ((v + 1) >>> 1) : v;
    endfunction

    function automatic longint twq(int k, bit im);
        real a, v, amp;
        a   = 2.0 * 3.14159265358979323846 * real'(k) / real'(NPTS);
        amp = real'((1 << (TW - 1)) - 1);
        v   = im ? -$sin(a) * amp : $cos(a) * amp;
        return longint'($rtoi((v >= 0.0) ? v + 0.5 : v - 0.5));
    endfunction

    function automatic void model_reset();
        pos       = 0;
        have_prev = 1'b0;
        frame_inv = 1'b0;
    endfunction

    function automatic void model_accept(longint xr, longint xi, bit iv, int tag);
        exp_t   e;
        longint dr, di, wr, wi, pr, pi;
        if (pos == 0)
            frame_inv = iv;
        cur_re[pos] = xr;
        cur_im[pos] = xi;
        e.tag = tag;
        if (pos < HALF) begin
            if (have_prev) begin
                dr = scl(prv_re[pos] - prv_re[pos + HALF]);
                di = scl(prv_im[pos] - prv_im[pos + HALF]);
                wr = twq(pos, 1'b0);
                wi = twq(pos, 1'b1);
                if (frame_inv)
                    wi = -wi;
                pr = dr * wr - di * wi;
                pi = dr * wi + di * wr;
                e.re = clamp((pr + (longint'(1) <<< (TW - 2))) >>> (TW - 1));
                e.im = clamp((pi + (longint'(1) <<< (TW - 2))) >>> (TW - 1));
                sb.push_back(e);
            end
        end else begin
            e.re = clamp(scl(cur_re[pos - HALF] + xr));
            e.im = clamp(scl(cur_im[pos - HALF] + xi));
            sb.push_back(e);
        end
        pos++;
        if (pos == NPTS) begin
            prv_re    = cur_re;
            prv_im    = cur_im;
            have_prev = 1'b1;
            pos       = 0;
        end
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_re", longint'(out_re), e.re);
                chk("out_im", longint'(out_im), e.im);
                chk("latency", longint'(cyc - e.tag), 2);
            end
        end else if (sb.size() > 0 && sb[0].tag + 2 <= cyc) begin
            e = sb.pop_front();
            chk("missing_out_valid", 0, 1);
        end
    end

    task automatic drive(input bit v, input int re, input int im, input bit iv);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = v;
        in_re    = DW'(re);
        in_im    = DW'(im);
        inv      = iv;
        if (v)
            model_accept(longint'(re), longint'(im), iv, cyc);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic gap();
        drive(1'b0, rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_re", longint'(out_re), 0);
        chk("rst_out_im", longint'(out_im), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = DW'(rnd_s());
        in_im    = DW'(rnd_s());
        // Anything accepted in the last cycle is still inside the pipeline and is lost.
        while (sb.size() > 0 && sb[$].tag >= cyc - 1)
            void'(sb.pop_back());
        model_reset();
        @(posedge clk);
        #1;
        chk("flush_out_valid", longint'(out_valid), 0);
        chk("flush_out_re", longint'(out_re), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d expected outputs pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n    = 1'b0;
        flush    = 1'b0;
        inv      = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("por_out_valid", longint'(out_valid), 0);
        chk("por_out_re", longint'(out_re), 0);
        chk("por_out_im", longint'(out_im), 0);
        rst_n = 1'b1;

        // impulse frames, forward
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < NPTS; n++)
                drive(1'b1, (n == 0) ? 1000 : 0, 0, 1'b0);

        // impulse frames, inverse latched at frame start, inv toggling mid-frame
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < NPTS; n++)
                drive(1'b1, (n == 0) ? 1000 : 0, (n == 1) ? 500 : 0,
                      (n == 0) ? 1'b1 : 1'(n % 2));

        // extreme values: full-scale differences and alternating rails
        for (int f = 0; f < 4; f++)
            for (int n = 0; n < NPTS; n++) begin
                if (f < 2)
                    drive(1'b1, (n < HALF) ? 32767 : -32768, (n < HALF) ? 32767 : -32768, 1'(f));
                else
                    drive(1'b1, (n % 2 != 0) ? -32768 : 32767, (n % 2 != 0) ? 32767 : -32768, 1'(f));
            end

        // random data with ~30% idle cycles and random inv
        for (int f = 0; f < 50; f++)
            for (int n = 0; n < NPTS; n++) begin
                for (int g = 0; g < 8 && $urandom_range(0, 99) < 30; g++)
                    gap();
                drive(1'b1, rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));
            end

        // reset mid-frame, then restart from sample 0
        for (int n = 0; n < 3; n++)
            drive(1'b1, rnd_s(), rnd_s(), 1'b0);
        do_reset();
        for (int n = 0; n < 2 * NPTS; n++)
            drive(1'b1, rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));

        // flush mid-frame with in_valid high
        for (int n = 0; n < 5; n++)
            drive(1'b1, rnd_s(), rnd_s(), 1'b0);
        do_flush();
        for (int n = 0; n < 3 * NPTS; n++) begin
            if ($urandom_range(0, 99) < 30)
                gap();
            drive(1'b1, rnd_s(), rnd_s(), 1'($urandom_range(0, 1)));
        end

        repeat (6) gap();
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
